pdp8l_xbr_arbiter: RTL and testbench

//  32Kx12 block-RAM owner sitting directly downstream of the extended-memory controller's xbr* port.

---
 rtl/pdp8l_xbr_pkg.sv | 17 +
 rtl/pdp8l_xbr_ram.sv | 52 +++++
 rtl/pdp8l_xbr_arbiter.sv | 134 +++++++++++++
 tb/tb_pdp8l_xbr_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdp8l_xbr_pkg.sv
// Shared definitions for the xbr RAM arbiter: secondary FSM encoding, ident word, ARM register map.
package pdp8l_xbr_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } xbr_state_t;

   localparam logic [31:0] XBR_IDENT  = 32'h5841_1001;

   localparam logic [1:0]  REG_IDENT  = 2'd0;
   localparam logic [1:0]  REG_USAGE  = 2'd1;
   localparam logic [1:0]  REG_STALL  = 2'd2;
   localparam logic [1:0]  REG_STATUS = 2'd3;

endpackage

// File: rtl/pdp8l_xbr_ram.sv
// Single-port 12-bit synchronous RAM with a READLAT-deep read pipe; each read carries a
// primary/secondary tag so a result always returns to the port that issued it.
module pdp8l_xbr_ram #(
   parameter int AW      = 15,
   parameter int READLAT = 1
) (
   input  logic          CLOCK,
   input  logic          RESET,
   input  logic          en,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [11:0]   wdat,
   input  logic          pri_rd,
   input  logic          sec_rd,
   output logic [11:0]   rdat,
   output logic          pri_valid,
   output logic          sec_valid
);

   logic [11:0]        mem   [2**AW];
   logic [11:0]        dpipe [READLAT];
   logic [READLAT-1:0] ppipe;
   logic [READLAT-1:0] spipe;

   // Contents are deliberately not reset.
   always_ff @(posedge CLOCK) begin
      if (en) begin
         if (we) mem[addr] <= wdat;
         dpipe[0] <= mem[addr];
      end
      for (int i = 1; i < READLAT; i++) dpipe[i] <= dpipe[i-1];
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         ppipe <= '0;
         spipe <= '0;
      end else begin
         ppipe[0] <= en & pri_rd;
         spipe[0] <= en & sec_rd;
         for (int i = 1; i < READLAT; i++) begin
            ppipe[i] <= ppipe[i-1];
            spipe[i] <= spipe[i-1];
         end
      end
   end

   assign rdat      = dpipe[READLAT-1];
   assign pri_valid = ppipe[READLAT-1];
   assign sec_valid = spipe[READLAT-1];

endmodule

// File: rtl/pdp8l_xbr_arbiter.sv
// Owner of the 32Kx12 xbr RAM: primary port has absolute priority, a secondary DMA port
// is served by a small FSM, and ARM-readable ident/usage/stall registers are exposed.
module pdp8l_xbr_arbiter
   import pdp8l_xbr_pkg::*;
#(
   parameter int AW      = 15,
   parameter int READLAT = 1
) (
   input  logic          CLOCK,
   input  logic          RESET,
   input  logic          armwrite,
   input  logic [1:0]    armraddr,
   input  logic [1:0]    armwaddr,
   input  logic [31:0]   armwdata,
   output logic [31:0]   armrdata,
   input  logic [AW-1:0] xbraddr,
   input  logic [11:0]   xbrwdat,
   input  logic          xbrenab,
   input  logic          xbrwena,
   output logic [11:0]   xbrrdat,
   input  logic          sreq,
   input  logic [AW-1:0] saddr,
   input  logic [11:0]   swdat,
   input  logic          swena,
   output logic          sack,
   output logic [11:0]   srdat
);

   localparam logic [1:0] LAT_INIT = 2'(READLAT - 1);

   xbr_state_t    state_q, state_d;
   logic [1:0]    lat_q, lat_d;
   logic          ack_last;
   logic          enab_last;
   logic          sec_go;
   logic          stall;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [11:0]   ram_wdat;
   logic [11:0]   rdat;
   logic          pri_valid;
   logic          sec_valid;
   logic [11:0]   xbr_hold;
   logic [11:0]   srdat_q;
   logic [15:0]   pricnt;
   logic [15:0]   seccnt;
   logic [31:0]   stallcnt;

   // ARM writes act purely as clear strobes; the data word carries nothing.
   logic unused_wdata;
   assign unused_wdata = ^armwdata;

   // sreq is ignored in ACK and the cycle after it, so a late-dropping requester is not re-served.
   assign sec_go   = (state_q == IDLE) & sreq & ~ack_last & ~xbrenab;
   assign stall    = (state_q == IDLE) & sreq & ~ack_last &  xbrenab;
   assign ram_we   = xbrenab ? xbrwena : swena;
   assign ram_addr = xbrenab ? xbraddr : saddr;
   assign ram_wdat = xbrenab ? xbrwdat : swdat;

   pdp8l_xbr_ram #(.AW(AW), .READLAT(READLAT)) u_ram (
      .CLOCK     (CLOCK),
      .RESET     (RESET),
      .en        (xbrenab | sec_go),
      .we        (ram_we),
      .addr      (ram_addr),
      .wdat      (ram_wdat),
      .pri_rd    (xbrenab & ~xbrwena),
      .sec_rd    (sec_go & ~swena),
      .rdat      (rdat),
      .pri_valid (pri_valid),
      .sec_valid (sec_valid)
   );

   always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      case (state_q)
         IDLE: if (sec_go) begin
            state_d = WAIT;
            lat_d   = LAT_INIT;
         end
         WAIT: if (lat_q == 2'd0) state_d = ACK;
               else               lat_d   = lat_q - 2'd1;
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q   <= IDLE;
         lat_q     <= 2'd0;
         ack_last  <= 1'b0;
         enab_last <= 1'b0;
         xbr_hold  <= 12'd0;
         srdat_q   <= 12'd0;
         pricnt    <= 16'd0;
         seccnt    <= 16'd0;
         stallcnt  <= 32'd0;
      end else begin
         state_q   <= state_d;
         lat_q     <= lat_d;
         ack_last  <= (state_q == ACK);
         enab_last <= xbrenab;
         if (pri_valid) xbr_hold <= rdat;
         if (sec_valid) srdat_q  <= rdat;
         if (armwrite && armwaddr == REG_USAGE) begin
            pricnt <= 16'd0;
            seccnt <= 16'd0;
         end else begin
            if (xbrenab && !enab_last) pricnt <= pricnt + 16'd1;
            if (sec_go)                seccnt <= seccnt + 16'd1;
         end
         if (armwrite && armwaddr == REG_STALL)  stallcnt <= 32'd0;
         else if (stall && stallcnt != '1)      stallcnt <= stallcnt + 32'd1;
      end
   end

   assign sack    = (state_q == ACK);
   assign srdat   = srdat_q;
   assign xbrrdat = pri_valid ? rdat : xbr_hold;

   always_comb begin
      armrdata = 32'd0;
      case (armraddr)
         REG_IDENT:  armrdata = XBR_IDENT;
         REG_USAGE:  armrdata = {pricnt, seccnt};
         REG_STALL:  armrdata = stallcnt;
         REG_STATUS: armrdata = {sreq, sack, state_q, 28'd0};
         default:    armrdata = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_pdp8l_xbr_arbiter.sv
// Bench for the xbr arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_pdp8l_xbr_arbiter;

   localparam int RL = 2;
   localparam int RN = 400;

   logic        CLOCK;
   logic        RESET;
   logic        armwrite;
   logic [1:0]  armraddr;
   logic [1:0]  armwaddr;
   logic [31:0] armwdata;
   logic [31:0] armrdata;
   logic [14:0] xbraddr;
   logic [11:0] xbrwdat;
   logic        xbrenab;
   logic        xbrwena;
   logic [11:0] xbrrdat;
   logic        sreq;
   logic [14:0] saddr;
   logic [11:0] swdat;
   logic        swena;
   logic        sack;
   logic [11:0] srdat;

   int vectors;
   int miscompares;

   pdp8l_xbr_arbiter #(.AW(15), .READLAT(RL)) dut (
      .CLOCK    (CLOCK),
      .RESET    (RESET),
      .armwrite (armwrite),
      .armraddr (armraddr),
      .armwaddr (armwaddr),
      .armwdata (armwdata),
      .armrdata (armrdata),
      .xbraddr  (xbraddr),
      .xbrwdat  (xbrwdat),
      .xbrenab  (xbrenab),
      .xbrwena  (xbrwena),
      .xbrrdat  (xbrrdat),
      .sreq     (sreq),
      .saddr    (saddr),
      .swdat    (swdat),
      .swena    (swena),
      .sack     (sack),
      .srdat    (srdat)
   );

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge CLOCK);
      #1;
   endtask

   task automatic rd_arm(input logic [1:0] r, output logic [31:0] v);
      armraddr = r;
      #1;
      v = armrdata;
   endtask

   task automatic arm_clear(input logic [1:0] r);
      armwrite = 1'b1;
      armwaddr = r;
      armwdata = $urandom;
      tick();
      armwrite = 1'b0;
   endtask

   task automatic test_reset;
      logic [31:0] v;
      RESET = 1'b1;
      tick();
      tick();
      RESET = 1'b0;
      tick();
      vectors++; if (xbrrdat !== 12'd0) begin miscompares++; $display("FAIL reset_xbrrdat got %o want 0", xbrrdat); end
      vectors++; if (srdat !== 12'd0) begin miscompares++; $display("FAIL reset_srdat got %o want 0", srdat); end
      vectors++; if (sack !== 1'b0) begin miscompares++; $display("FAIL reset_sack got %b want 0", sack); end
      rd_arm(2'd0, v);
      vectors++; if (v !== 32'h5841_1001) begin miscompares++; $display("FAIL reset_ident got %h want 58411001", v); end
      rd_arm(2'd1, v);
      vectors++; if (v !== 32'd0) begin miscompares++; $display("FAIL reset_usage got %h want 0", v); end
      rd_arm(2'd2, v);
      vectors++; if (v !== 32'd0) begin miscompares++; $display("FAIL reset_stall got %h want 0", v); end
      rd_arm(2'd3, v);
      vectors++; if (v !== 32'd0) begin miscompares++; $display("FAIL reset_status got %h want 0", v); end
   endtask

   task automatic test_primary_rw;
      xbraddr = 15'o17777;
      xbrwdat = 12'o1234;
      xbrwena = 1'b1;
      xbrenab = 1'b1;
      repeat (5) tick();
      xbrenab = 1'b0;
      xbrwena = 1'b0;
      tick();
      xbrenab = 1'b1;
      repeat (RL - 1) tick();
      vectors++; if (xbrrdat !== 12'd0) begin miscompares++; $display("FAIL p1_early got %o want 0", xbrrdat); end
      tick();
      vectors++; if (xbrrdat !== 12'o1234) begin miscompares++; $display("FAIL p1_read got %o want 1234", xbrrdat); end
      xbrenab = 1'b0;
      tick();
      tick();
      vectors++; if (xbrrdat !== 12'o1234) begin miscompares++; $display("FAIL p1_hold got %o want 1234", xbrrdat); end
   endtask

   task automatic test_sec_read;
      logic [31:0] v;
      xbraddr = 15'o100;
      xbrwdat = 12'o7070;
      xbrwena = 1'b1;
      xbrenab = 1'b1;
      tick();
      xbrenab = 1'b0;
      xbrwena = 1'b0;
      arm_clear(2'd1);
      sreq  = 1'b1;
      saddr = 15'o100;
      swena = 1'b0;
      for (int j = 0; j <= RL + 1; j++) begin
         vectors++; if (sack !== (j == RL + 1)) begin miscompares++; $display("FAIL s2_sack_timing cyc %0d got %b want %b", j, sack, j == RL + 1); end
         if (j == RL + 1) begin
            vectors++; if (srdat !== 12'o7070) begin miscompares++; $display("FAIL s2_srdat got %o want 7070", srdat); end
         end
         tick();
      end
      tick();
      sreq = 1'b0;
      repeat (2 * RL + 4) begin
         vectors++; if (sack !== 1'b0) begin miscompares++; $display("FAIL s4_regrant got sack %b want 0", sack); end
         tick();
      end
      rd_arm(2'd1, v);
      vectors++; if (v !== 32'h0000_0001) begin miscompares++; $display("FAIL s4_usage got %h want 00000001", v); end
   endtask

   task automatic test_stall;
      logic [31:0] v;
      arm_clear(2'd1);
      arm_clear(2'd2);
      xbraddr = 15'o17777;
      xbrwena = 1'b0;
      xbrenab = 1'b1;
      sreq    = 1'b1;
      saddr   = 15'o100;
      swena   = 1'b0;
      for (int i = 0; i < 5; i++) begin
         rd_arm(2'd3, v);
         vectors++; if (v[30:28] !== 3'b000) begin miscompares++; $display("FAIL s3_blocked cyc %0d got %b want 000", i, v[30:28]); end
         tick();
      end
      xbrenab = 1'b0;
      rd_arm(2'd2, v);
      vectors++; if (v !== 32'd5) begin miscompares++; $display("FAIL s3_stallcnt got %0d want 5", v); end
      tick();
      rd_arm(2'd3, v);
      vectors++; if (v[29:28] !== 2'd1) begin miscompares++; $display("FAIL s3_grant got state %0d want 1", v[29:28]); end
      repeat (RL - 1) tick();
      vectors++; if (sack !== 1'b0) begin miscompares++; $display("FAIL s3_sack_early got %b want 0", sack); end
      tick();
      vectors++; if (sack !== 1'b1) begin miscompares++; $display("FAIL s3_sack got %b want 1", sack); end
      vectors++; if (srdat !== 12'o7070) begin miscompares++; $display("FAIL s3_srdat got %o want 7070", srdat); end
      sreq = 1'b0;
      tick();
      rd_arm(2'd1, v);
      vectors++; if (v !== 32'h0001_0001) begin miscompares++; $display("FAIL s3_usage got %h want 00010001", v); end
      rd_arm(2'd2, v);
      vectors++; if (v !== 32'd5) begin miscompares++; $display("FAIL s3_stall_after got %0d want 5", v); end
   endtask

   task automatic test_raw;
      logic [31:0] v;
      int n;
      arm_clear(2'd1);
      sreq  = 1'b1;
      saddr = 15'o2222;
      swena = 1'b1;
      swdat = 12'o5555;
      n = 0;
      while (sack !== 1'b1 && n < 20) begin tick(); n++; end
      vectors++; if (sack !== 1'b1) begin miscompares++; $display("FAIL s5_sack_timeout got %b want 1", sack); end
      vectors++; if (srdat !== 12'o7070) begin miscompares++; $display("FAIL s5_srdat_write got %o want 7070", srdat); end
      sreq  = 1'b0;
      swena = 1'b0;
      tick();
      xbraddr = 15'o2222;
      xbrwena = 1'b0;
      xbrenab = 1'b1;
      repeat (3) tick();
      vectors++; if (xbrrdat !== 12'o5555) begin miscompares++; $display("FAIL s5_raw got %o want 5555", xbrrdat); end
      xbrenab = 1'b0;
      tick();
      xbraddr = 15'o17777;
      xbrenab = 1'b1;
      repeat (2) tick();
      xbrenab = 1'b0;
      tick();
      vectors++; if (xbrrdat !== 12'o1234) begin miscompares++; $display("FAIL s5_second_burst got %o want 1234", xbrrdat); end
      rd_arm(2'd1, v);
      vectors++; if (v !== 32'h0002_0001) begin miscompares++; $display("FAIL s5_usage got %h want 00020001", v); end
   endtask

   task automatic test_reset_mid;
      logic [31:0] v;
      int n;
      sreq  = 1'b1;
      saddr = 15'o100;
      swena = 1'b0;
      tick();
      rd_arm(2'd3, v);
      vectors++; if (v[29:28] !== 2'd1) begin miscompares++; $display("FAIL s6_in_wait got state %0d want 1", v[29:28]); end
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      sreq  = 1'b0;
      rd_arm(2'd3, v);
      vectors++; if (v !== 32'd0) begin miscompares++; $display("FAIL s6_status got %h want 0", v); end
      rd_arm(2'd1, v);
      vectors++; if (v !== 32'd0) begin miscompares++; $display("FAIL s6_usage got %h want 0", v); end
      rd_arm(2'd2, v);
      vectors++; if (v !== 32'd0) begin miscompares++; $display("FAIL s6_stall got %h want 0", v); end
      repeat (RL + 3) begin
         vectors++; if (sack !== 1'b0 || srdat !== 12'd0) begin miscompares++; $display("FAIL s6_abandon got sack %b srdat %o want 0 0", sack, srdat); end
         tick();
      end
      xbraddr = 15'o17777;
      xbrwena = 1'b0;
      xbrenab = 1'b1;
      sreq    = 1'b1;
      repeat (3) tick();
      rd_arm(2'd2, v);
      vectors++; if (v !== 32'd3) begin miscompares++; $display("FAIL s6_stall_pre got %0d want 3", v); end
      armwrite = 1'b1;
      armwaddr = 2'd2;
      tick();
      armwrite = 1'b0;
      rd_arm(2'd2, v);
      vectors++; if (v !== 32'd0) begin miscompares++; $display("FAIL s6_clear_wins got %0d want 0", v); end
      tick();
      rd_arm(2'd2, v);
      vectors++; if (v !== 32'd1) begin miscompares++; $display("FAIL s6_stall_resume got %0d want 1", v); end
      xbrenab = 1'b0;
      n = 0;
      while (sack !== 1'b1 && n < 20) begin tick(); n++; end
      vectors++; if (sack !== 1'b1) begin miscompares++; $display("FAIL s6_sack_timeout got %b want 1", sack); end
      sreq = 1'b0;
      tick();
   endtask

   task automatic test_random;
      logic [11:0] mem_m   [128];
      logic [11:0] due_val [RN + 8];
      bit          due     [RN + 8];
      logic [31:0] v;
      logic [11:0] xbr_exp, srd_exp, s_rval, s_wd, p_wd;
      logic [14:0] s_a, p_addr;
      bit          p_we, s_we, en_prev, s_active, s_granted, exp_sack;
      int          pri_left, pri_gap, s_gap, s_drop_at, s_elig, s_sack_at, last_sack;
      int          exp_pri, exp_sec, exp_stall;

      xbrenab = 1'b1;
      xbrwena = 1'b1;
      for (int a = 0; a < 128; a++) begin
         mem_m[a] = 12'($urandom_range(0, 4095));
         xbraddr  = 15'(a);
         xbrwdat  = mem_m[a];
         tick();
      end
      xbrenab = 1'b0;
      xbrwena = 1'b0;
      RESET = 1'b1;
      tick();
      RESET = 1'b0;

      for (int i = 0; i < RN + 8; i++) begin due[i] = 1'b0; due_val[i] = 12'd0; end
      xbr_exp = 12'd0; srd_exp = 12'd0; s_rval = 12'd0; s_wd = 12'd0; p_wd = 12'd0;
      s_a = 15'd0; p_addr = 15'd0; p_we = 1'b0; s_we = 1'b0;
      en_prev = 1'b0; s_active = 1'b0; s_granted = 1'b0;
      pri_left = 0; pri_gap = 0; s_gap = 0; s_drop_at = -1; s_elig = 0; s_sack_at = -1;
      last_sack = -100; exp_pri = 0; exp_sec = 0; exp_stall = 0;

      for (int k = 0; k < RN; k++) begin
         if (due[k]) xbr_exp = due_val[k];
         vectors++; if (xbrrdat !== xbr_exp) begin miscompares++; $display("FAIL rnd_xbrrdat cyc %0d got %o want %o", k, xbrrdat, xbr_exp); end
         exp_sack = s_granted && (k == s_sack_at);
         vectors++; if (sack !== exp_sack) begin miscompares++; $display("FAIL rnd_sack cyc %0d got %b want %b", k, sack, exp_sack); end
         if (exp_sack) begin
            if (!s_we) srd_exp = s_rval;
            s_granted = 1'b0;
            s_active  = 1'b0;
            last_sack = k;
            s_drop_at = k + int'($urandom_range(1, 2));
         end
         vectors++; if (srdat !== srd_exp) begin miscompares++; $display("FAIL rnd_srdat cyc %0d got %o want %o", k, srdat, srd_exp); end

         if (pri_left == 0 && pri_gap == 0 && k < RN - 20 && $urandom_range(0, 1) == 1) begin
            pri_left = int'($urandom_range(1, 4));
            p_addr   = 15'($urandom_range(0, 63));
            p_we     = 1'($urandom_range(0, 1));
            p_wd     = 12'($urandom_range(0, 4095));
         end
         if (pri_left > 0) begin
            xbrenab = 1'b1;
            xbraddr = p_addr;
            xbrwena = p_we;
            xbrwdat = p_wd;
            pri_left--;
            if (pri_left == 0) pri_gap = int'($urandom_range(1, 3));
         end else begin
            xbrenab = 1'b0;
            if (pri_gap > 0) pri_gap--;
         end
         if (xbrenab) begin
            if (!en_prev) exp_pri++;
            if (p_we) mem_m[p_addr[6:0]] = p_wd;
            else begin due[k + RL] = 1'b1; due_val[k + RL] = mem_m[p_addr[6:0]]; end
         end
         en_prev = xbrenab;

         if (s_drop_at == k) begin
            sreq      = 1'b0;
            s_drop_at = -1;
            s_gap     = int'($urandom_range(0, 3));
         end else if (!s_active && s_drop_at < 0) begin
            if (s_gap > 0) s_gap--;
            else if (k < RN - 20 && $urandom_range(0, 2) == 0) begin
               s_active  = 1'b1;
               s_granted = 1'b0;
               s_a       = 15'(64 + $urandom_range(0, 63));
               s_we      = 1'($urandom_range(0, 1));
               s_wd      = 12'($urandom_range(0, 4095));
               sreq      = 1'b1;
               saddr     = s_a;
               swena     = s_we;
               swdat     = s_wd;
               s_elig    = (last_sack + 2 > k) ? last_sack + 2 : k;
            end
         end

         if (s_active && !s_granted && k >= s_elig) begin
            if (xbrenab) exp_stall++;
            else begin
               s_granted = 1'b1;
               s_sack_at = k + RL + 1;
               exp_sec++;
               if (s_we) mem_m[s_a[6:0]] = s_wd;
               else      s_rval = mem_m[s_a[6:0]];
            end
         end
         tick();
      end
      sreq    = 1'b0;
      xbrenab = 1'b0;
      rd_arm(2'd1, v);
      vectors++; if (v !== {16'(exp_pri), 16'(exp_sec)}) begin miscompares++; $display("FAIL rnd_usage got %h want %h", v, {16'(exp_pri), 16'(exp_sec)}); end
      rd_arm(2'd2, v);
      vectors++; if (v !== 32'(exp_stall)) begin miscompares++; $display("FAIL rnd_stall got %0d want %0d", v, exp_stall); end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      RESET    = 1'b1;
      armwrite = 1'b0;
      armraddr = 2'd0;
      armwaddr = 2'd0;
      armwdata = 32'd0;
      xbraddr  = 15'd0;
      xbrwdat  = 12'd0;
      xbrenab  = 1'b0;
      xbrwena  = 1'b0;
      sreq     = 1'b0;
      saddr    = 15'd0;
      swdat    = 12'd0;
      swena    = 1'b0;
      test_reset();
      test_primary_rw();
      test_sec_read();
      test_stall();
      test_raw();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
